imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Registered, parametrised immediate generator for the decode stage of the pipelined core.
//  - Accepts an instruction word plus optional immediate selector over a valid/ready handshake.
//  - Returns the XLEN-wide immediate one cycle later through a 2-entry skid buffer, so
//    back-pressure from execute never drops or duplicates an instruction.
//  - Adds RV64 width support, opcode-driven auto-decode and a CSR zimm format to the
//    single-cycle generator.
// PARAMETERS
//  XLEN         32  immediate/output width; legal values 32 or 64
//  AUTO_DECODE  0   0: format taken from in_sel; 1: format derived from inst[6:0], in_sel ignored
//  TAG_W        5   width of sideband tag carried alongside the instruction (e.g. rd/ROB id)
// PORTS
//  clk        input   1      rising-edge clock
//  rst        input   1      synchronous reset, active-high
//  in_valid   input   1      upstream holds a valid instruction
//  in_ready   output  1      stage can accept; transfer when in_valid & in_ready
//  in_inst    input   32     instruction word
//  in_sel     input   3      format: 0 I/JALR, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR zimm), 6-7 reserved
//  in_tag     input   TAG_W  sideband, passed unchanged
//  out_valid  output  1      imm_out/out_tag valid
//  out_ready  input   1      downstream accepts; transfer when out_valid & out_ready
//  imm_out    output  XLEN   generated immediate
//  out_tag    output  TAG_W  tag of the instruction presented
//  out_fmt    output  3      format actually used (resolved selector)
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=0 during rst, 1 the cycle after; imm_out, out_tag, out_fmt = 0.
//    Both buffer entries cleared; a transfer pending in the reset cycle is discarded.
//  - Formats (s = inst[31], sign-extended to XLEN):
//    I {s,inst[30:20]}; S {s,inst[30:25],inst[11:7]}; B {s,inst[7],inst[30:25],inst[11:8],0};
//    U {s,inst[30:12],12'b0} (sign-extended on RV64); J {s,inst[19:12],inst[20],inst[30:21],0};
//    Z zero-extended inst[19:15]; reserved -> imm 0.
//  - AUTO_DECODE=1: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B;
//    0110111/0010111 -> U; 1101111 -> J; 1110011 -> Z if inst[14]=1 else I; any other opcode -> 7.
//  - Latency: immediate computed combinationally, registered on accept; first out_valid
//    the cycle after the in_valid&in_ready transfer. Throughput 1/cycle when out_ready=1.
//  - Skid buffer: main reg + skid reg. Accept while main is not presented, or presented and
//    draining, goes to main. Accept while main is stalled (out_valid & !out_ready) goes to skid.
//    in_ready = !skid_full (registered; no combinational path from out_ready).
//  - Drain: when main transfers and skid is full, skid moves to main the same edge; skid clears.
//  - Simultaneous accept + drain with skid empty: main reloads with new data, out_valid stays 1.
//  - Full (both entries, out_ready=0): in_ready=0; outputs held stable, no changes until drain.
//  - Order strictly FIFO; imm_out/out_tag/out_fmt must not change while out_valid & !out_ready.
//  - Reset mid-operation: both entries discarded; no output after rst deasserts until a new accept.
// CONFIGURATION
//  IMM_ILLEGAL_CHK_EN defined: extra output port illegal (1 bit), registered with the entry;
//    1 when the resolved format is 6 or 7; imm_out forced 0. Reset value 0.
//  Undefined: port absent; reserved formats silently produce imm 0.
// TESTING
//  - XLEN=32, in_sel=0, inst 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, imm_out=0xFFFFFFFF.
//  - AUTO_DECODE=1, inst 0xFE000EE3 (beq -4) -> out_fmt=2, imm_out=0xFFFFFFFC; inst 0x0010006F
//    (jal +2048) -> out_fmt=4, imm_out=0x00000800.
//  - XLEN=64, in_sel=3, inst 0x800000B7 -> imm_out=0xFFFFFFFF80000000; inst 0x123450B7
//    -> 0x0000000012345000.
//  - Back-pressure: tags 1,2,3 sent back-to-back with out_ready=0 -> in_ready low after 2
//    accepts, tag 3 held off; raise out_ready -> tags 1,2,3 out in order, no gaps or duplicates.
//  - Reset with both entries full -> out_valid=0 the cycle after rst; in_ready=1 one cycle after
//    rst deasserts; no stale tag emitted.
//  - IMM_ILLEGAL_CHK_EN, AUTO_DECODE=1, inst 0x0000007F -> out_fmt=7, illegal=1, imm_out=0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate generator: 1-cycle latency, 2-entry skid buffer, in_ready registered.
// Optional IMM_ILLEGAL_CHK_EN adds an 'illegal' output flagging reserved formats.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_fmt
`ifdef IMM_ILLEGAL_CHK_EN
  ,
  output logic             illegal
`endif
);

  localparam logic [2:0] FMT_I   = 3'd0;
  localparam logic [2:0] FMT_S   = 3'd1;
  localparam logic [2:0] FMT_B   = 3'd2;
  localparam logic [2:0] FMT_U   = 3'd3;
  localparam logic [2:0] FMT_J   = 3'd4;
  localparam logic [2:0] FMT_Z   = 3'd5;
  localparam logic [2:0] FMT_BAD = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic [2:0]       fmt;
`ifdef IMM_ILLEGAL_CHK_EN
    logic             ill;
`endif
  } entry_t;

  logic [2:0]      fmt;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            sgn;
  entry_t          new_e;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_vld, main_vld_d;
  logic   skid_vld, skid_vld_d;
  logic   rdy_q;
  logic   accept;

  // Format resolution: explicit selector, or opcode decode when AUTO_DECODE is set.
  always_comb begin
    fmt = in_sel;
    if (AUTO_DECODE != 0) begin
      case (in_inst[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
        7'b0100011:                         fmt = FMT_S;
        7'b1100011:                         fmt = FMT_B;
        7'b0110111, 7'b0010111:             fmt = FMT_U;
        7'b1101111:                         fmt = FMT_J;
        7'b1110011:                         fmt = in_inst[14] ? FMT_Z : FMT_I;
        default:                            fmt = FMT_BAD;
      endcase
    end
  end

  assign sgn = in_inst[31];

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{21{sgn}}, in_inst[30:20]};
      FMT_S:   imm32 = {{21{sgn}}, in_inst[30:25], in_inst[11:7]};
      FMT_B:   imm32 = {{20{sgn}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      FMT_U:   imm32 = {sgn, in_inst[30:12], 12'b0};
      FMT_J:   imm32 = {{12{sgn}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      FMT_Z:   imm32 = {27'b0, in_inst[19:15]};
      default: imm32 = '0;
    endcase
  end

  // Every 32-bit form is already correctly signed, so RV64 is a plain sign-extension.
  generate
    if (XLEN > 32) begin : g_wide
      assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm_ext = imm32[XLEN-1:0];
    end
  endgenerate

  always_comb begin
    new_e     = '0;
    new_e.imm = imm_ext;
    new_e.tag = in_tag;
    new_e.fmt = fmt;
`ifdef IMM_ILLEGAL_CHK_EN
    new_e.ill = (fmt == 3'd6) || (fmt == 3'd7);
    if (new_e.ill) new_e.imm = '0;
`endif
  end

  assign accept = in_valid & rdy_q;

  // Main register presents to execute; skid only fills while main is stalled.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld;
    skid_vld_d = skid_vld;
    if (!main_vld || out_ready) begin
      if (skid_vld) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = new_e;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = new_e;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_vld <= main_vld_d;
      skid_vld <= skid_vld_d;
      rdy_q    <= !skid_vld_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_vld;
  assign imm_out   = main_q.imm;
  assign out_tag   = main_q.tag;
  assign out_fmt   = main_q.fmt;
`ifdef IMM_ILLEGAL_CHK_EN
  assign illegal   = main_q.ill;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (RV32 selector, RV32 auto-decode, RV64 selector) share stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_sel;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        r32_in_ready, r32_out_valid;
  logic [31:0] r32_imm;
  logic [4:0]  r32_tag;
  logic [2:0]  r32_fmt;
  logic        au_in_ready, au_out_valid;
  logic [31:0] au_imm;
  logic [4:0]  au_tag;
  logic [2:0]  au_fmt;
  logic        r64_in_ready, r64_out_valid;
  logic [63:0] r64_imm;
  logic [4:0]  r64_tag;
  logic [2:0]  r64_fmt;
`ifdef IMM_ILLEGAL_CHK_EN
  logic        r32_ill, au_ill, r64_ill;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(5)) u_r32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(r32_out_valid), .out_ready(out_ready), .imm_out(r32_imm),
    .out_tag(r32_tag), .out_fmt(r32_fmt)
`ifdef IMM_ILLEGAL_CHK_EN
    , .illegal(r32_ill)
`endif
  );

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(5)) u_au (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(au_in_ready),
    .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(au_out_valid), .out_ready(out_ready), .imm_out(au_imm),
    .out_tag(au_tag), .out_fmt(au_fmt)
`ifdef IMM_ILLEGAL_CHK_EN
    , .illegal(au_ill)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(0), .TAG_W(5)) u_r64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(r64_out_valid), .out_ready(out_ready), .imm_out(r64_imm),
    .out_tag(r64_tag), .out_fmt(r64_fmt)
`ifdef IMM_ILLEGAL_CHK_EN
    , .illegal(r64_ill)
`endif
  );

  // Hand-decoded vectors: inst, selector, RV32 result, auto fmt, auto result, RV64 result.
  localparam int NV = 10;
  logic [31:0] v_inst [NV] = '{32'hFFF00093, 32'hFE20AC23, 32'hFE000EE3, 32'h800000B7, 32'h123450B7,
                               32'h0010006F, 32'h300FD0F3, 32'h30009073, 32'h0000007F, 32'hFFF00093};
  logic [2:0]  v_sel  [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd6, 3'd7};
  logic [31:0] v_e32  [NV] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h80000000, 32'h12345000,
                               32'h00000800, 32'h0000001F, 32'h00000300, 32'h00000000, 32'h00000000};
  logic [2:0]  v_afmt [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7, 3'd0};
  logic [31:0] v_eau  [NV] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h80000000, 32'h12345000,
                               32'h00000800, 32'h0000001F, 32'h00000300, 32'h00000000, 32'hFFFFFFFF};
  logic [63:0] v_e64  [NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
                               64'hFFFFFFFF80000000, 64'h0000000012345000, 64'h0000000000000800,
                               64'h000000000000001F, 64'h0000000000000300, 64'h0, 64'h0};

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_inst = 32'hFFF00093; in_sel = 3'd0; in_tag = 5'd9; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (r32_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", r32_out_valid); end
    checks++; if (r32_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b expected 0", r32_in_ready); end
    checks++; if (r32_imm !== 32'h0) begin failures++; $display("FAIL rst_imm: got %h expected 0", r32_imm); end
    checks++; if (r32_tag !== 5'h0) begin failures++; $display("FAIL rst_tag: got %h expected 0", r32_tag); end
    checks++; if (r32_fmt !== 3'h0) begin failures++; $display("FAIL rst_fmt: got %h expected 0", r32_fmt); end
    checks++; if (r64_imm !== 64'h0) begin failures++; $display("FAIL rst_imm64: got %h expected 0", r64_imm); end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b expected 1", r32_in_ready); end
    checks++; if (r32_out_valid !== 1'b0) begin failures++; $display("FAIL rst_discard: got %b expected 0", r32_out_valid); end
  endtask

  // Back-to-back stream with out_ready=1: each vector must appear the cycle after its accept.
  task automatic test_formats();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_inst = v_inst[i]; in_sel = v_sel[i]; in_tag = 5'(i);
      @(posedge clk); @(negedge clk);
      checks++; if (r32_out_valid !== 1'b1) begin failures++; $display("FAIL fmt_valid[%0d]: got %b expected 1", i, r32_out_valid); end
      checks++; if (r32_imm !== v_e32[i]) begin failures++; $display("FAIL fmt_imm32[%0d]: got %h expected %h", i, r32_imm, v_e32[i]); end
      checks++; if (r32_fmt !== v_sel[i]) begin failures++; $display("FAIL fmt_sel[%0d]: got %0d expected %0d", i, r32_fmt, v_sel[i]); end
      checks++; if (r32_tag !== 5'(i)) begin failures++; $display("FAIL fmt_tag[%0d]: got %0d expected %0d", i, r32_tag, i); end
      checks++; if (au_fmt !== v_afmt[i]) begin failures++; $display("FAIL auto_fmt[%0d]: got %0d expected %0d", i, au_fmt, v_afmt[i]); end
      checks++; if (au_imm !== v_eau[i]) begin failures++; $display("FAIL auto_imm[%0d]: got %h expected %h", i, au_imm, v_eau[i]); end
      checks++; if (r64_imm !== v_e64[i]) begin failures++; $display("FAIL imm64[%0d]: got %h expected %h", i, r64_imm, v_e64[i]); end
      checks++; if (r32_in_ready !== 1'b1) begin failures++; $display("FAIL fmt_ready[%0d]: got %b expected 1", i, r32_in_ready); end
`ifdef IMM_ILLEGAL_CHK_EN
      checks++; if (au_ill !== (v_afmt[i] >= 3'd6)) begin failures++; $display("FAIL auto_illegal[%0d]: got %b expected %b", i, au_ill, (v_afmt[i] >= 3'd6)); end
      checks++; if (r32_ill !== (v_sel[i] >= 3'd6)) begin failures++; $display("FAIL sel_illegal[%0d]: got %b expected %b", i, r32_ill, (v_sel[i] >= 3'd6)); end
`endif
    end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_out_valid !== 1'b0) begin failures++; $display("FAIL fmt_idle: got %b expected 0", r32_out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_sel = 3'd0; in_tag = 5'd1;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_tag !== 5'd1 || r32_out_valid !== 1'b1) begin failures++; $display("FAIL bp_first: got v=%b tag=%0d expected v=1 tag=1", r32_out_valid, r32_tag); end
    checks++; if (r32_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1: got %b expected 1", r32_in_ready); end
    in_inst = 32'h123450B7; in_sel = 3'd3; in_tag = 5'd2;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full: got %b expected 0", r32_in_ready); end
    in_inst = 32'h0010006F; in_sel = 3'd4; in_tag = 5'd3;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (r32_in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", c, r32_in_ready); end
      checks++; if (r32_tag !== 5'd1 || r32_imm !== 32'hFFFFFFFF || r32_fmt !== 3'd0 || r32_out_valid !== 1'b1)
        begin failures++; $display("FAIL bp_stable[%0d]: got v=%b tag=%0d imm=%h fmt=%0d expected v=1 tag=1 imm=ffffffff fmt=0", c, r32_out_valid, r32_tag, r32_imm, r32_fmt); end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_tag !== 5'd2 || r32_imm !== 32'h12345000 || r32_out_valid !== 1'b1)
      begin failures++; $display("FAIL bp_drain2: got v=%b tag=%0d imm=%h expected v=1 tag=2 imm=12345000", r32_out_valid, r32_tag, r32_imm); end
    checks++; if (r32_in_ready !== 1'b1) begin failures++; $display("FAIL bp_reopen: got %b expected 1", r32_in_ready); end
    @(posedge clk); @(negedge clk);
    checks++; if (r32_tag !== 5'd3 || r32_imm !== 32'h00000800 || r32_out_valid !== 1'b1)
      begin failures++; $display("FAIL bp_drain3: got v=%b tag=%0d imm=%h expected v=1 tag=3 imm=00000800", r32_out_valid, r32_tag, r32_imm); end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup: got %b expected 0", r32_out_valid); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_sel = 3'd0; in_tag = 5'd4;
    @(posedge clk); @(negedge clk);
    in_tag = 5'd5;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_in_ready !== 1'b0) begin failures++; $display("FAIL rf_full: got %b expected 0", r32_in_ready); end
    in_tag = 5'd6; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_out_valid !== 1'b0 || au_out_valid !== 1'b0) begin failures++; $display("FAIL rf_valid: got %b expected 0", r32_out_valid); end
    checks++; if (r32_tag !== 5'd0) begin failures++; $display("FAIL rf_tag: got %0d expected 0", r32_tag); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_in_ready !== 1'b1) begin failures++; $display("FAIL rf_ready: got %b expected 1", r32_in_ready); end
    for (int c = 0; c < 2; c++) begin
      checks++; if (r32_out_valid !== 1'b0) begin failures++; $display("FAIL rf_stale[%0d]: got v=%b tag=%0d expected v=0", c, r32_out_valid, r32_tag); end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b1; in_inst = 32'h0010006F; in_sel = 3'd4; in_tag = 5'd10;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_out_valid !== 1'b1 || r32_tag !== 5'd10 || r32_imm !== 32'h00000800)
      begin failures++; $display("FAIL rf_new: got v=%b tag=%0d imm=%h expected v=1 tag=10 imm=00000800", r32_out_valid, r32_tag, r32_imm); end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (r32_out_valid !== 1'b0) begin failures++; $display("FAIL rf_end: got %b expected 0", r32_out_valid); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
